simon_iter_ctrl: RTL and testbench

Iterative sequencer for the SIMON 32/64 datapath. Owns the round-key store, the round counter and the block state register, and time-multiplexes one external combinational round function and one key-expansion function. It performs key loading (full schedule expansion), encryption and decryption under a start/busy/done handshake. It sits between the packet front-end and the round/key-expansion logic.

---
 rtl/simon_pkg.sv | 34 +++
 rtl/simon_key_ram.sv | 41 ++++
 rtl/simon_iter_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_simon_iter_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and default parameters for the SIMON 32/64 iterative sequencer.
package simon_pkg;

  // SIMON 32/64 default geometry
  localparam int SIMON_N  = 16;
  localparam int SIMON_M  = 4;
  localparam int SIMON_T  = 32;
  localparam int SIMON_CB = 5;

  // Operation requested on the mode input
  typedef enum logic [1:0] {
    KEYLOAD = 2'b00,
    ENC     = 2'b01,
    DEC     = 2'b10,
    RSVD    = 2'b11
  } mode_e;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_KEXP = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  // z0 constant sequence, written first bit first: z0[i] is bit (61 - i)
  localparam logic [61:0] SIMON_Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  // Returns element idx of the z0 sequence (period 62)
  function automatic logic z0Bit(input int unsigned idx);
    return SIMON_Z0[61 - (idx % 62)];
  endfunction

endpackage

// File: rtl/simon_key_ram.sv
// Round-key register file: T words of N bits, one write port, one async read port.
// A seed port loads the first M words in a single edge when a new key arrives.
module simon_key_ram
  import simon_pkg::*;
#(
  parameter int N  = SIMON_N,
  parameter int M  = SIMON_M,
  parameter int T  = SIMON_T,
  parameter int Cb = SIMON_CB
) (
  input  logic                 clk,
  input  logic                 nR,
  input  logic                 seedEn,
  input  logic [M-1:0][N-1:0]  seedKeys,
  input  logic                 wrEn,
  input  logic [Cb-1:0]        wrAddr,
  input  logic [N-1:0]         wrData,
  input  logic [Cb-1:0]        rdAddr,
  output logic [N-1:0]         rdData
);

  logic [N-1:0] mem_q [T];

  // Storage update: clear on reset, seed the user key words, or write one expanded word
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      for (int i = 0; i < T; i++) begin
        mem_q[i] <= '0;
      end
    end else if (seedEn) begin
      for (int i = 0; i < M; i++) begin
        mem_q[i] <= seedKeys[i];
      end
    end else if (wrEn) begin
      mem_q[wrAddr] <= wrData;
    end
  end

  assign rdData = mem_q[rdAddr];

endmodule

// File: rtl/simon_iter_ctrl.sv
// Iterative SIMON 32/64 sequencer: key-schedule expansion, encryption and
// decryption around an external round function and key-expansion function.
module simon_iter_ctrl
  import simon_pkg::*;
#(
  parameter int N  = SIMON_N,
  parameter int M  = SIMON_M,
  parameter int T  = SIMON_T,
  parameter int Cb = SIMON_CB
) (
  input  logic                 clk,
  input  logic                 nR,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [M-1:0][N-1:0]  keyIn,
  input  logic [1:0][N-1:0]    blockIn,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 keyValid,
  output logic [1:0][N-1:0]    blockOut,
  output logic [1:0][N-1:0]    rndIn,
  output logic [N-1:0]         rndKey,
  input  logic [1:0][N-1:0]    rndOut,
  output logic [Cb-1:0]        keCount,
  output logic [M-1:0][N-1:0]  keKeys,
  input  logic [N-1:0]         keOut
);

  // Terminal counter values: last round, and last expansion step (writes word T-1)
  localparam logic [Cb-1:0] LastRound = Cb'(T - 1);
  localparam logic [Cb-1:0] LastExp   = Cb'(T - M - 1);

  state_e               state_q, state_d;
  logic [Cb-1:0]        cnt_q, cnt_d;
  logic [1:0][N-1:0]    blk_q, blk_d;
  logic [M-1:0][N-1:0]  win_q, win_d;
  logic [1:0][N-1:0]    out_q, out_d;
  logic                 dec_q, dec_d;
  logic                 keyValid_q, keyValid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 seedEn;
  logic                 wrEn;
  logic [Cb-1:0]        wrAddr;
  logic [Cb-1:0]        rdAddr;
  logic [N-1:0]         rdData;
  mode_e                reqMode;

  assign reqMode = mode_e'(mode);

  // Expanded words land M places above the expansion index
  assign wrAddr = cnt_q + Cb'(M);

  // Round key: forward order for encrypt, reversed for decrypt, word 0 when not running
  always_comb begin
    rdAddr = '0;
    if (state_q == ST_RUN) begin
      rdAddr = dec_q ? (LastRound - cnt_q) : cnt_q;
    end
  end

  simon_key_ram #(
    .N  (N),
    .M  (M),
    .T  (T),
    .Cb (Cb)
  ) u_key_ram (
    .clk      (clk),
    .nR       (nR),
    .seedEn   (seedEn),
    .seedKeys (keyIn),
    .wrEn     (wrEn),
    .wrAddr   (wrAddr),
    .wrData   (keOut),
    .rdAddr   (rdAddr),
    .rdData   (rdData)
  );

  // Next-state logic: request decode in IDLE, one expansion step or one round per edge otherwise
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    blk_d      = blk_q;
    win_d      = win_q;
    out_d      = out_q;
    dec_d      = dec_q;
    keyValid_d = keyValid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    seedEn     = 1'b0;
    wrEn       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (reqMode)
            KEYLOAD: begin
              keyValid_d = 1'b0;
              seedEn     = 1'b1;
              win_d      = keyIn;
              cnt_d      = '0;
              state_d    = ST_KEXP;
            end
            ENC, DEC: begin
              if (keyValid_q) begin
                dec_d   = (reqMode == DEC);
                blk_d   = (reqMode == DEC) ? {blockIn[0], blockIn[1]} : blockIn;
                cnt_d   = '0;
                state_d = ST_RUN;
              end else begin
                err_d = 1'b1;
              end
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end

      ST_KEXP: begin
        wrEn  = 1'b1;
        win_d = {keOut, win_q[M-1:1]};
        if (cnt_q == LastExp) begin
          cnt_d      = '0;
          keyValid_d = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        blk_d = rndOut;
        if (cnt_q == LastRound) begin
          cnt_d   = '0;
          out_d   = dec_q ? {rndOut[0], rndOut[1]} : rndOut;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial schedule
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      blk_q      <= '0;
      win_q      <= '0;
      out_q      <= '0;
      dec_q      <= 1'b0;
      keyValid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
      win_q      <= win_d;
      out_q      <= out_d;
      dec_q      <= dec_d;
      keyValid_q <= keyValid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign keyValid = keyValid_q;
  assign blockOut = out_q;
  assign rndIn    = blk_q;
  assign rndKey   = rdData;
  assign keCount  = cnt_q;
  assign keKeys   = win_q;

endmodule

// File: tb/tb_simon_iter_ctrl.sv
// Testbench for simon_iter_ctrl: supplies the combinational round and key-expansion
// functions and compares every cycle against a transaction-level SIMON model.
module tb_simon_iter_ctrl;

  localparam logic [1:0] MKEY = 2'b00;
  localparam logic [1:0] MENC = 2'b01;
  localparam logic [1:0] MDEC = 2'b10;
  localparam logic [1:0] MRSV = 2'b11;

  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  logic              clk;
  logic              nR;
  logic              start;
  logic [1:0]        mode;
  logic [3:0][15:0]  keyIn;
  logic [1:0][15:0]  blockIn;
  logic              busy;
  logic              done;
  logic              err;
  logic              keyValid;
  logic [1:0][15:0]  blockOut;
  logic [1:0][15:0]  rndIn;
  logic [15:0]       rndKey;
  logic [1:0][15:0]  rndOut;
  logic [4:0]        keCount;
  logic [3:0][15:0]  keKeys;
  logic [15:0]       keOut;

  int total = 0;
  int bad   = 0;
  bit chkOn = 0;

  // SIMON primitives
  function automatic logic [15:0] rol(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  function automatic logic [31:0] roundF(input logic [31:0] st, input logic [15:0] k);
    logic [15:0] x;
    logic [15:0] y;
    x = st[31:16];
    y = st[15:0];
    return {y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ k, x};
  endfunction

  function automatic logic [15:0] keyExp(input logic [3:0][15:0] w, input int idx);
    logic [15:0] tmp;
    logic [15:0] zw;
    tmp = ror(w[3], 3) ^ w[1];
    tmp = tmp ^ ror(tmp, 1);
    zw  = {15'd0, Z0[61 - idx]};
    return ~w[0] ^ tmp ^ zw ^ 16'd3;
  endfunction

  function automatic logic [31:0] swapHalves(input logic [31:0] v);
    return {v[15:0], v[31:16]};
  endfunction

  // External combinational blocks around the sequencer
  assign rndOut = roundF(rndIn, rndKey);
  assign keOut  = keyExp(keKeys, int'(keCount));

  simon_iter_ctrl dut (
    .clk      (clk),
    .nR       (nR),
    .start    (start),
    .mode     (mode),
    .keyIn    (keyIn),
    .blockIn  (blockIn),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .keyValid (keyValid),
    .blockOut (blockOut),
    .rndIn    (rndIn),
    .rndKey   (rndKey),
    .rndOut   (rndOut),
    .keCount  (keCount),
    .keKeys   (keKeys),
    .keOut    (keOut)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: one outstanding transaction with its full expected trajectory
  int          cyc;
  bit          opActive;
  int          opKind;
  int          opStart;
  int          opEnd;
  logic        expBusy;
  logic        expDone;
  logic        expErr;
  logic        expKv;
  logic [31:0] expBlk;
  logic [31:0] holdState;
  logic [15:0] sched [32];
  logic [15:0] keys  [32];
  logic [31:0] traj  [33];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model advance on each edge: completion, acceptance or rejection of a request
  always @(posedge clk or negedge nR) begin
    if (!nR) begin
      cyc = 0; opActive = 0; opKind = 0; opStart = 0; opEnd = 0;
      expBusy = 0; expDone = 0; expErr = 0; expKv = 0;
      expBlk = '0; holdState = '0;
      for (int i = 0; i < 32; i++) begin
        keys[i] = '0;
        sched[i] = '0;
      end
    end else begin
      cyc++;
      expDone = 0;
      expErr  = 0;
      if (opActive) begin
        if (cyc == opEnd) begin
          opActive = 0;
          expDone  = 1;
          if (opKind == 0) begin
            expKv = 1;
            for (int i = 0; i < 32; i++) keys[i] = sched[i];
          end else begin
            holdState = traj[32];
            expBlk    = (opKind == 2) ? swapHalves(traj[32]) : traj[32];
          end
        end
      end else if (start) begin
        if (mode == MKEY) begin
          for (int i = 0; i < 4; i++) sched[i] = keyIn[i];
          for (int i = 0; i < 28; i++)
            sched[i+4] = keyExp({sched[i+3], sched[i+2], sched[i+1], sched[i]}, i);
          opActive = 1; opKind = 0; opStart = cyc; opEnd = cyc + 28;
          expKv = 0;
        end else if ((mode == MENC || mode == MDEC) && expKv) begin
          opKind  = (mode == MDEC) ? 2 : 1;
          traj[0] = (opKind == 2) ? swapHalves(blockIn) : blockIn;
          for (int i = 0; i < 32; i++)
            traj[i+1] = roundF(traj[i], (opKind == 2) ? keys[31-i] : keys[i]);
          opActive = 1; opStart = cyc; opEnd = cyc + 32;
        end else begin
          expErr = 1;
        end
      end
      expBusy = opActive;
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (chkOn) begin
      int j;
      j = cyc - opStart;
      checkOutput("busy", 64'(busy), 64'(expBusy));
      checkOutput("done", 64'(done), 64'(expDone));
      checkOutput("err", 64'(err), 64'(expErr));
      checkOutput("keyValid", 64'(keyValid), 64'(expKv));
      checkOutput("blockOut", 64'(blockOut), 64'(expBlk));
      if (opActive && opKind != 0) begin
        checkOutput("rndIn", 64'(rndIn), 64'(traj[j]));
        checkOutput("rndKey", 64'(rndKey), 64'((opKind == 2) ? keys[31-j] : keys[j]));
      end else begin
        checkOutput("rndIn", 64'(rndIn), 64'(holdState));
      end
      if (opActive && opKind == 0) begin
        checkOutput("keCount", 64'(keCount), 64'(j));
        checkOutput("keKeys", 64'(keKeys), {sched[j+3], sched[j+2], sched[j+1], sched[j]});
      end
    end
  end

  // Presents a request for exactly one edge; returns just after that edge
  task automatic applyStimulus(input logic [1:0] m, input logic [63:0] k, input logic [31:0] b);
    start   = 1'b1;
    mode    = m;
    keyIn   = k;
    blockIn = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles until done; e=0 is the cycle after the edge preceding the call
  task automatic waitDone(output int e);
    e = -1;
    while (e < 80) begin
      @(negedge clk);
      e++;
      if (done === 1'b1) break;
    end
  endtask

  // One-cycle start pulse while the sequencer is busy
  task automatic pulseWhileBusy(input logic [1:0] m);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Watchdog
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lat;
    int r;
    logic [1:0] m;
    bit accepted;

    nR = 1'b1; start = 1'b0; mode = MKEY; keyIn = '0; blockIn = '0;
    #1 nR = 1'b0;
    chkOn = 1;
    repeat (2) @(posedge clk);
    #1 nR = 1'b1;

    @(negedge clk);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetKeyValid", 64'(keyValid), 64'd0);
    checkOutput("resetBlockOut", 64'(blockOut), 64'd0);

    applyStimulus(MENC, 64'd0, 32'h12345678);
    @(negedge clk);
    checkOutput("errNoKey", 64'(err), 64'd1);

    applyStimulus(MRSV, 64'd0, 32'd0);
    @(negedge clk);
    checkOutput("errReserved", 64'(err), 64'd1);
    checkOutput("errReservedBusy", 64'(busy), 64'd0);

    applyStimulus(MKEY, 64'h1918_1110_0908_0100, 32'd0);
    waitDone(lat);
    checkOutput("keyLoadLatency", 64'(lat), 64'd28);
    checkOutput("keyLoadValid", 64'(keyValid), 64'd1);

    @(negedge clk);
    applyStimulus(MENC, 64'd0, 32'h6565_6877);
    waitDone(lat);
    checkOutput("encLatency", 64'(lat), 64'd32);
    checkOutput("encResult", 64'(blockOut), 64'h0000_0000_c69b_e9bb);
    checkOutput("modelEncResult", 64'(expBlk), 64'h0000_0000_c69b_e9bb);

    @(negedge clk);
    applyStimulus(MDEC, 64'd0, 32'hc69b_e9bb);
    pulseWhileBusy(MKEY);
    waitDone(lat);
    checkOutput("decLatencyAfterPulse", 64'(lat), 64'd28);
    checkOutput("decResult", 64'(blockOut), 64'h0000_0000_6565_6877);
    checkOutput("decKeepsKey", 64'(keyValid), 64'd1);

    applyStimulus(MENC, 64'd0, 32'h6565_6877);
    waitDone(lat);
    checkOutput("b2bEncLatency", 64'(lat), 64'd32);
    checkOutput("b2bEncResult", 64'(blockOut), 64'h0000_0000_c69b_e9bb);
    applyStimulus(MDEC, 64'd0, 32'hc69b_e9bb);
    waitDone(lat);
    checkOutput("b2bDecLatency", 64'(lat), 64'd32);
    checkOutput("b2bDecResult", 64'(blockOut), 64'h0000_0000_6565_6877);
    checkOutput("modelDecResult", 64'(expBlk), 64'h0000_0000_6565_6877);

    for (int it = 0; it < 5; it++) begin
      applyStimulus(MKEY, {$urandom, $urandom}, 32'd0);
      waitDone(lat);
      checkOutput("randKeyLatency", 64'(lat), 64'd28);
      for (int op = 0; op < 6; op++) begin
        r = $urandom_range(0, 9);
        m = (r < 4) ? MENC : (r < 8) ? MDEC : (r == 8) ? MRSV : MKEY;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        accepted = (m == MKEY) || ((m == MENC || m == MDEC) && expKv);
        applyStimulus(m, {$urandom, $urandom}, $urandom);
        if (accepted) begin
          if ($urandom_range(0, 1) == 1) begin
            pulseWhileBusy(2'($urandom_range(0, 3)));
            waitDone(lat);
            checkOutput("randLatencyPulsed", 64'(lat), (m == MKEY) ? 64'd24 : 64'd28);
          end else begin
            waitDone(lat);
            checkOutput("randLatency", 64'(lat), (m == MKEY) ? 64'd28 : 64'd32);
          end
        end else begin
          @(negedge clk);
        end
      end
    end

    @(negedge clk);
    applyStimulus(MKEY, 64'h0123_4567_89ab_cdef, 32'd0);
    repeat (10) @(posedge clk);
    #1 nR = 1'b0;
    @(negedge clk);
    checkOutput("midResetBusy", 64'(busy), 64'd0);
    checkOutput("midResetKeyValid", 64'(keyValid), 64'd0);
    checkOutput("midResetBlockOut", 64'(blockOut), 64'd0);
    @(posedge clk);
    #1 nR = 1'b1;
    @(negedge clk);
    applyStimulus(MENC, 64'd0, 32'h6565_6877);
    @(negedge clk);
    checkOutput("errAfterReset", 64'(err), 64'd1);
    repeat (2) @(negedge clk);

    chkOn = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
